// File: rtl/mod8_ctrl_pkg.sv
// Shared state encodings and constants for the
// mod-8 round controller and its counter.
package mod8_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] CNT_MAX = 3'd7;

endpackage

// File: rtl/cnt_mod8_en.sv
// Mod-8 counter with enable and synchronous clear;
// wrap flags the enabled 7->0 edge.
module cnt_mod8_en
  import mod8_ctrl_pkg::*;
(
  input  logic       cp,
  input  logic       clr,
  input  logic       en,
  input  logic       sclr,
  output logic [3:0] Q,
  output logic       wrap
);

  logic [2:0] cnt;

  always_ff @(posedge cp or posedge clr) begin
    if (clr)
      cnt <= '0;
    else if (sclr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 3'd1;
  end

  assign Q    = {1'b0, cnt};
  assign wrap = en & (cnt == CNT_MAX);

endmodule

// File: rtl/mod8_round_ctrl.sv
// Runs the mod-8 counter through a latched number
// of full passes per start, with pause/hold support.
module mod8_round_ctrl
  import mod8_ctrl_pkg::*;
#(
  parameter int ROUND_W = 4
) (
  input  logic               cp,
  input  logic               clr,
  input  logic               start,
  input  logic [ROUND_W-1:0] rounds,
  input  logic               pause,
  output logic [3:0]         Q,
  output logic               qcc,
  output logic               busy,
  output logic               done,
  output logic [ROUND_W-1:0] rnd_cnt
);

  state_t state, state_nx;

  logic [ROUND_W-1:0] rounds_q;
  logic [ROUND_W-1:0] rnd_inc;
  logic               en;
  logic               sclr;
  logic               wrap;
  logic               accept;

  assign accept  = (state == ST_IDLE) & start;
  assign rnd_inc = rnd_cnt + 1'b1;

  cnt_mod8_en u_cnt (
    .cp   (cp),
    .clr  (clr),
    .en   (en),
    .sclr (sclr),
    .Q    (Q),
    .wrap (wrap)
  );

  always_ff @(posedge cp or posedge clr) begin
    if (clr)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    en       = 1'b0;
    sclr     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          sclr     = 1'b1;
          state_nx = (rounds == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (pause) begin
          state_nx = ST_HOLD;
        end else begin
          en = 1'b1;
          if (wrap && (rnd_inc == rounds_q))
            state_nx = ST_DONE;
        end
      end
      // resume edge never counts
      ST_HOLD: begin
        if (!pause)
          state_nx = ST_RUN;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge cp or posedge clr) begin
    if (clr) begin
      rounds_q <= '0;
      rnd_cnt  <= '0;
    end else if (accept) begin
      rounds_q <= rounds;
      rnd_cnt  <= '0;
    end else if (wrap) begin
      rnd_cnt  <= rnd_inc;
    end
  end

  assign qcc  = wrap;
  assign busy = (state == ST_RUN) | (state == ST_HOLD);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mod8_round_ctrl.sv
// Randomized, model-checked bench for mod8_round_ctrl.
module tb_mod8_round_ctrl;

  logic       cp = 1'b0;
  logic       clr;
  logic       start;
  logic [3:0] rounds;
  logic       pause;
  logic [3:0] Q;
  logic       qcc;
  logic       busy;
  logic       done;
  logic [3:0] rnd_cnt;

  int total = 0;
  int bad   = 0;

  // reference: total increments done in the run
  int m_cnt    = 0;
  int m_target = 0;
  bit m_act    = 0;
  bit m_hold   = 0;
  bit m_done   = 0;

  mod8_round_ctrl #(.ROUND_W(4)) dut (
    .cp      (cp),
    .clr     (clr),
    .start   (start),
    .rounds  (rounds),
    .pause   (pause),
    .Q       (Q),
    .qcc     (qcc),
    .busy    (busy),
    .done    (done),
    .rnd_cnt (rnd_cnt)
  );

  always #5 cp = ~cp;

  function automatic logic [10:0] exp_vec();
    logic [3:0] eq;
    logic [3:0] er;
    logic       ec;
    eq = 4'(m_cnt % 8);
    er = 4'(m_cnt / 8);
    ec = m_act && !m_hold && !pause && (m_cnt % 8 == 7);
    return {eq, ec, m_act, m_done, er};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {Q, qcc, busy, done, rnd_cnt};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_target = 0;
    m_act = 0; m_hold = 0; m_done = 0;
  endtask

  task automatic model_step();
    if (m_done) begin
      m_done = 0;
    end else if (m_act) begin
      if (m_hold) begin
        if (!pause) m_hold = 0;
      end else if (pause) begin
        m_hold = 1;
      end else begin
        m_cnt++;
        if (m_cnt == m_target) begin
          m_act  = 0;
          m_done = 1;
        end
      end
    end else if (start) begin
      m_cnt = 0;
      if (rounds == 0) begin
        m_done = 1;
      end else begin
        m_act    = 1;
        m_target = 8 * int'(rounds);
      end
    end
  endtask

  task automatic drive(input bit s, input int r, input bit p);
    start  = s;
    rounds = 4'(r);
    pause  = p;
  endtask

  task automatic edge_step();
    @(posedge cp);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] o;
    clr = 1'b1;
    drive(0, 0, 0);
    model_reset();
    #12;
    total++;
    if (obs_vec() !== 11'd0) begin
      bad++;
      $display("FAIL reset_init got=%h want=0", obs_vec());
    end
    clr = 1'b0;
    drive(1, 4, 0);
    edge_step();
    drive(0, 4, 0);
    for (int i = 0; i < 5; i++) edge_step();
    total++;
    if (Q !== 4'd5) begin
      bad++;
      $display("FAIL reset_pre_q got=%0d want=5", Q);
    end
    #3 clr = 1'b1;
    #1;
    model_reset();
    o = obs_vec();
    total++;
    if (o !== 11'd0) begin
      bad++;
      $display("FAIL reset_async got=%h want=0", o);
    end
    #2 clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, $urandom_range(0, 15), 0);
      edge_step();
      total++;
      if (obs_vec() !== exp_vec() || Q !== 4'd0) begin
        bad++;
        $display("FAIL reset_idle got=%h want=%h",
                 obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_two_rounds();
    int nq;
    nq = 0;
    drive(1, 2, 0);
    edge_step();
    total++;
    if (obs_vec() !== exp_vec() || busy !== 1'b1 || Q !== 4'd0) begin
      bad++;
      $display("FAIL two_start got=%h want=%h", obs_vec(), exp_vec());
    end
    for (int i = 1; i <= 17; i++) begin
      drive(0, $urandom_range(0, 15), 0);
      edge_step();
      if (qcc) nq++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL two_cyc%0d got=%h want=%h",
                 i, obs_vec(), exp_vec());
      end
      if (i == 16) begin
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || rnd_cnt !== 4'd2) begin
          bad++;
          $display("FAIL two_done got=%b%b%0d want=102",
                   done, busy, rnd_cnt);
        end
      end
    end
    total++;
    if (nq != 2) begin
      bad++;
      $display("FAIL two_qcc got=%0d want=2", nq);
    end
  endtask

  task automatic test_pause_mid();
    drive(1, 1, 0);
    edge_step();
    for (int i = 1; i <= 13; i++) begin
      drive(0, 1, (i >= 4 && i <= 6));
      edge_step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL pmid_cyc%0d got=%h want=%h",
                 i, obs_vec(), exp_vec());
      end
      if (i >= 3 && i <= 7) begin
        total++;
        if (Q !== 4'd3 || busy !== 1'b1) begin
          bad++;
          $display("FAIL pmid_hold%0d got=q%0d b%b want=q3 b1",
                   i, Q, busy);
        end
      end
      if (i == 12) begin
        total++;
        if (done !== 1'b1) begin
          bad++;
          $display("FAIL pmid_done got=%b want=1", done);
        end
      end
    end
  endtask

  task automatic test_pause_wrap();
    int nd;
    nd = 0;
    drive(1, 1, 0);
    edge_step();
    drive(0, 1, 0);
    for (int i = 0; i < 7; i++) edge_step();
    total++;
    if (qcc !== 1'b1 || Q !== 4'd7) begin
      bad++;
      $display("FAIL pwrap_pre got=q%0d c%b want=q7 c1", Q, qcc);
    end
    drive(0, 1, 1);
    #1;
    total++;
    if (qcc !== 1'b0) begin
      bad++;
      $display("FAIL pwrap_qcc_drop got=%b want=0", qcc);
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, (i < 2));
      edge_step();
      if (done) nd++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL pwrap_cyc%0d got=%h want=%h",
                 i, obs_vec(), exp_vec());
      end
    end
    total++;
    if (nd != 1 || rnd_cnt !== 4'd1) begin
      bad++;
      $display("FAIL pwrap_end got=d%0d r%0d want=d1 r1", nd, rnd_cnt);
    end
  endtask

  task automatic test_zero_rounds();
    drive(1, 0, 0);
    edge_step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || Q !== 4'd0 ||
        rnd_cnt !== 4'd0) begin
      bad++;
      $display("FAIL zero_done got=%h want=%h", obs_vec(), exp_vec());
    end
    drive(0, 0, 0);
    edge_step();
    total++;
    if (obs_vec() !== exp_vec() || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL zero_idle got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 3, 0);
    edge_step();
    for (int i = 1; i <= 26; i++) begin
      if (i == 10 || i == 24) drive(1, 15, 0);
      else drive(0, 3, 0);
      edge_step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL b2b_cyc%0d got=%h want=%h",
                 i, obs_vec(), exp_vec());
      end
      if (i == 24) begin
        total++;
        if (done !== 1'b1 || rnd_cnt !== 4'd3) begin
          bad++;
          $display("FAIL b2b_done got=d%b r%0d want=d1 r3",
                   done, rnd_cnt);
        end
      end
      if (i == 25) begin
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || Q !== 4'd0) begin
          bad++;
          $display("FAIL b2b_idle got=%h want=busy0 done0 q0",
                   obs_vec());
        end
      end
    end
  endtask

  task automatic test_random();
    int budget;
    for (int run = 0; run < 8; run++) begin
      drive(1, $urandom_range(0, 3), 0);
      edge_step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rnd%0d_start got=%h want=%h",
                 run, obs_vec(), exp_vec());
      end
      budget = 0;
      while ((m_act || m_done) && budget < 200) begin
        drive(($urandom_range(0, 7) == 0), $urandom_range(0, 15),
              ($urandom_range(0, 3) == 0));
        edge_step();
        budget++;
        total++;
        if (obs_vec() !== exp_vec()) begin
          bad++;
          $display("FAIL rnd%0d_cyc%0d got=%h want=%h",
                   run, budget, obs_vec(), exp_vec());
        end
      end
      if (budget >= 200) begin
        total++;
        bad++;
        $display("FAIL rnd%0d_timeout got=busy%b want=idle", run, busy);
        model_reset();
        clr = 1'b1;
        #2 clr = 1'b0;
      end
      drive(0, 0, 0);
      edge_step();
    end
  endtask

  initial begin
    test_reset();
    test_two_rounds();
    test_pause_mid();
    test_pause_wrap();
    test_zero_rounds();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
